// File: rtl/t07_ext_reg_arbiter.sv
// Round-robin read arbiter sharing the external register bank's single read port
// between the memory handler (port 0) and the aux/display fetch (port 1).
module t07_ext_reg_arbiter #(
  parameter int ADDR_W  = 5,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic [1:0]        req_i,
  input  logic [ADDR_W-1:0] addr0_i,
  input  logic [ADDR_W-1:0] addr1_i,
  output logic [DATA_W-1:0] rdata_o,
  output logic [1:0]        done_o,
  output logic [1:0]        err_o,
  output logic              busy_o,
  output logic [ADDR_W-1:0] reg_addr_o,
  output logic              reg_ri_o,
  input  logic              reg_ack_i,
  input  logic [DATA_W-1:0] reg_rdata_i
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WAIT    = 2'd1,
    S_CAPTURE = 2'd2,
    S_RELEASE = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic               gnt_q, gnt_d;
  logic               last_gnt_q, last_gnt_d;
  logic [CNT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic [ADDR_W-1:0]  reg_addr_q, reg_addr_d;
  logic [DATA_W-1:0]  rdata_q, rdata_d;
  logic [1:0]         done_q, done_d;
  logic [1:0]         err_q, err_d;
  logic               gnt_sel;
  logic [1:0]         gnt_onehot;

  // On contention the port that did not win last time gets the bank.
  assign gnt_sel    = (req_i == 2'b11) ? ~last_gnt_q : req_i[1];
  assign gnt_onehot = gnt_q ? 2'b10 : 2'b01;

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    last_gnt_d = last_gnt_q;
    wait_cnt_d = wait_cnt_q;
    reg_addr_d = reg_addr_q;
    rdata_d    = rdata_q;
    done_d     = 2'b00;
    err_d      = 2'b00;
    case (state_q)
      S_IDLE: begin
        if (req_i != 2'b00) begin
          gnt_d      = gnt_sel;
          reg_addr_d = gnt_sel ? addr1_i : addr0_i;
          wait_cnt_d = '0;
          state_d    = S_WAIT;
        end
      end
      S_WAIT: begin
        if (reg_ack_i) begin
          state_d = S_CAPTURE;
        end else if (wait_cnt_q == CNT_W'(TIMEOUT - 1)) begin
          rdata_d    = '0;
          done_d     = gnt_onehot;
          err_d      = gnt_onehot;
          last_gnt_d = gnt_q;
          state_d    = S_RELEASE;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      // Bank data is registered, so it is valid the cycle after ack.
      S_CAPTURE: begin
        rdata_d    = reg_rdata_i;
        done_d     = gnt_onehot;
        last_gnt_d = gnt_q;
        state_d    = S_RELEASE;
      end
      S_RELEASE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q    <= S_IDLE;
      gnt_q      <= 1'b0;
      last_gnt_q <= 1'b1;
      wait_cnt_q <= '0;
      reg_addr_q <= '0;
      rdata_q    <= '0;
      done_q     <= 2'b00;
      err_q      <= 2'b00;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      last_gnt_q <= last_gnt_d;
      wait_cnt_q <= wait_cnt_d;
      reg_addr_q <= reg_addr_d;
      rdata_q    <= rdata_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  // ri decoded straight from state so an async reset drops it at once.
  assign reg_ri_o   = (state_q == S_WAIT);
  assign busy_o     = (state_q != S_IDLE);
  assign reg_addr_o = reg_addr_q;
  assign rdata_o    = rdata_q;
  assign done_o     = done_q;
  assign err_o      = err_q;

endmodule

// File: tb/tb_t07_ext_reg_arbiter.sv
// Directed bench for t07_ext_reg_arbiter with a small register-bank model that
// acks on the rising edge of ri and returns registered data.
module tb_t07_ext_reg_arbiter;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic [1:0]  req_i = 2'b00;
  logic [4:0]  addr0_i = 5'd0;
  logic [4:0]  addr1_i = 5'd0;
  logic [31:0] rdata_o;
  logic [1:0]  done_o;
  logic [1:0]  err_o;
  logic        busy_o;
  logic [4:0]  reg_addr_o;
  logic        reg_ri_o;
  logic        reg_ack_i;
  logic [31:0] reg_rdata_i = 32'd0;

  logic        ack_en = 1'b1;
  logic        force_ack = 1'b0;
  logic        ri_prev;
  logic [31:0] bank [32];

  int checks = 0;
  int errors = 0;

  t07_ext_reg_arbiter #(.ADDR_W(5), .DATA_W(32), .TIMEOUT(15)) dut (
    .clk(clk), .nrst(nrst), .req_i(req_i), .addr0_i(addr0_i), .addr1_i(addr1_i),
    .rdata_o(rdata_o), .done_o(done_o), .err_o(err_o), .busy_o(busy_o),
    .reg_addr_o(reg_addr_o), .reg_ri_o(reg_ri_o), .reg_ack_i(reg_ack_i),
    .reg_rdata_i(reg_rdata_i)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge nrst) begin
    if (!nrst) ri_prev <= 1'b0;
    else       ri_prev <= reg_ri_o;
  end

  assign reg_ack_i = (ack_en && reg_ri_o && !ri_prev) || force_ack;

  always @(posedge clk) begin
    if (reg_ack_i) reg_rdata_i <= bank[reg_addr_o];
  end

  typedef struct {
    logic [1:0]  req;
    logic [4:0]  a0;
    logic [4:0]  a1;
    logic        ack;
    logic [1:0]  done;
    logic [1:0]  err;
    logic [31:0] rdata;
    int          lat;
    int          ri;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    req_i  = 2'b00;
    nrst   = 1'b0;
    repeat (2) @(negedge clk);
    nrst   = 1'b1;
    @(negedge clk);
  endtask

  // Runs until done_o pulses (bounded); returns edges taken and ri-high cycles seen.
  task automatic run_txn(output int lat, output int ri_cnt, output logic [1:0] dn,
                         output logic [1:0] er, output logic [31:0] rd, output logic ri_d);
    lat = 0; ri_cnt = 0; dn = 2'b00; er = 2'b00; rd = '0; ri_d = 1'b0;
    while (lat < 100) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
      if (reg_ri_o) ri_cnt++;
      if (done_o != 2'b00) begin
        dn = done_o; er = err_o; rd = rdata_o; ri_d = reg_ri_o;
        break;
      end
    end
    if (dn == 2'b00) begin
      checks++;
      errors++;
      $display("FAIL txn_timeout actual=no_done required=done_within_100");
    end
  endtask

  initial begin
    int lat, ric;
    logic [1:0] dn, er;
    logic [31:0] rd;
    logic rid;
    logic [1:0] exp_order [4];

    for (int i = 0; i < 32; i++) bank[i] = 32'hB000_0000 | i;
    bank[5] = 32'h1234_5678;

    vecs[0] = '{2'b01, 5'd5,  5'd0,  1'b1, 2'b01, 2'b00, 32'h1234_5678, 3, 1};
    vecs[1] = '{2'b10, 5'd0,  5'd31, 1'b1, 2'b10, 2'b00, 32'hB000_001F, 3, 1};
    vecs[2] = '{2'b10, 5'd0,  5'd6,  1'b0, 2'b10, 2'b10, 32'h0000_0000, 16, 15};
    vecs[3] = '{2'b01, 5'd7,  5'd0,  1'b1, 2'b01, 2'b00, 32'hB000_0007, 3, 1};
    vecs[4] = '{2'b01, 5'd0,  5'd0,  1'b0, 2'b01, 2'b01, 32'h0000_0000, 16, 15};
    vecs[5] = '{2'b11, 5'd2,  5'd9,  1'b1, 2'b10, 2'b00, 32'hB000_0009, 3, 1};

    do_reset();
    chk("rst_rdata", rdata_o, 32'd0);
    chk("rst_done", {30'd0, done_o}, 32'd0);
    chk("rst_err", {30'd0, err_o}, 32'd0);
    chk("rst_busy", {31'd0, busy_o}, 32'd0);
    chk("rst_ri", {31'd0, reg_ri_o}, 32'd0);
    chk("rst_addr", {27'd0, reg_addr_o}, 32'd0);

    for (int v = 0; v < 6; v++) begin
      ack_en  = vecs[v].ack;
      addr0_i = vecs[v].a0;
      addr1_i = vecs[v].a1;
      req_i   = vecs[v].req;
      run_txn(lat, ric, dn, er, rd, rid);
      req_i = 2'b00;
      chk($sformatf("v%0d_done", v), {30'd0, dn}, {30'd0, vecs[v].done});
      chk($sformatf("v%0d_err", v), {30'd0, er}, {30'd0, vecs[v].err});
      chk($sformatf("v%0d_rdata", v), rd, vecs[v].rdata);
      chk($sformatf("v%0d_lat", v), lat, vecs[v].lat);
      chk($sformatf("v%0d_ri_cycles", v), ric, vecs[v].ri);
      chk($sformatf("v%0d_ri_at_done", v), {31'd0, rid}, 32'd0);
      @(negedge clk);
      chk($sformatf("v%0d_idle_busy", v), {31'd0, busy_o}, 32'd0);
      chk($sformatf("v%0d_idle_done", v), {30'd0, done_o}, 32'd0);
    end

    // Contention from reset: both held, grants alternate starting with port 0.
    ack_en = 1'b1;
    do_reset();
    addr0_i = 5'd3;
    addr1_i = 5'd31;
    req_i   = 2'b11;
    exp_order[0] = 2'b01; exp_order[1] = 2'b10; exp_order[2] = 2'b01; exp_order[3] = 2'b10;
    for (int k = 0; k < 4; k++) begin
      run_txn(lat, ric, dn, er, rd, rid);
      chk($sformatf("cont%0d_done", k), {30'd0, dn}, {30'd0, exp_order[k]});
      chk($sformatf("cont%0d_rdata", k), rd, (k % 2 == 0) ? 32'hB000_0003 : 32'hB000_001F);
      // Later reads include the IDLE cycle: ri low CAPTURE, RELEASE, IDLE.
      chk($sformatf("cont%0d_lat", k), lat, (k == 0) ? 3 : 4);
      chk($sformatf("cont%0d_ri", k), ric, 1);
    end
    req_i = 2'b00;
    @(negedge clk);

    // Async reset in WAIT.
    ack_en  = 1'b0;
    addr0_i = 5'd2;
    req_i   = 2'b01;
    @(negedge clk);
    chk("rstwait_ri_before", {31'd0, reg_ri_o}, 32'd1);
    #2 nrst = 1'b0;
    #1;
    chk("rstwait_ri_now", {31'd0, reg_ri_o}, 32'd0);
    chk("rstwait_busy_now", {31'd0, busy_o}, 32'd0);
    chk("rstwait_addr_now", {27'd0, reg_addr_o}, 32'd0);
    chk("rstwait_rdata_now", rdata_o, 32'd0);
    @(negedge clk);
    chk("rstwait_done", {30'd0, done_o}, 32'd0);
    chk("rstwait_err", {30'd0, err_o}, 32'd0);
    req_i = 2'b00;
    nrst  = 1'b1;
    @(negedge clk);
    ack_en  = 1'b1;
    addr0_i = 5'd4;
    req_i   = 2'b01;
    run_txn(lat, ric, dn, er, rd, rid);
    req_i = 2'b00;
    chk("postrst_done", {30'd0, dn}, 32'd1);
    chk("postrst_rdata", rd, 32'hB000_0004);
    chk("postrst_lat", lat, 3);
    @(negedge clk);

    // req_i[1] dropped and addr changed while in WAIT.
    addr1_i = 5'd12;
    req_i   = 2'b10;
    @(negedge clk);
    chk("drop_ri_wait", {31'd0, reg_ri_o}, 32'd1);
    req_i   = 2'b00;
    addr1_i = 5'd20;
    run_txn(lat, ric, dn, er, rd, rid);
    chk("drop_done", {30'd0, dn}, 32'd2);
    chk("drop_err", {30'd0, er}, 32'd0);
    chk("drop_rdata", rd, 32'hB000_000C);
    chk("drop_lat", lat, 2);
    @(negedge clk);
    chk("drop_busy1", {31'd0, busy_o}, 32'd0);
    @(negedge clk);
    chk("drop_busy2", {31'd0, busy_o}, 32'd0);
    chk("drop_done2", {30'd0, done_o}, 32'd0);

    // Ack while IDLE must be ignored.
    force_ack = 1'b1;
    @(negedge clk);
    force_ack = 1'b0;
    @(negedge clk);
    chk("spur_busy", {31'd0, busy_o}, 32'd0);
    chk("spur_done", {30'd0, done_o}, 32'd0);
    chk("spur_rdata", rdata_o, 32'hB000_000C);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
